// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, SPI mode constants
// and the counter-width helper used to size the divider and bit counters.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD
  } spi_state_t;

  // Mode 0, MSB first: sclk idles low, data is sampled on the leading edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Width for a counter holding 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks while en is high;
// the count is held at zero while en is low so each transfer starts aligned.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first. Optional build macro SPI_MASTER_LOOPBACK_EN
// feeds the internally driven mosi back into the rx shift register instead of miso.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso
);

  localparam int BW = cnt_width(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  spi_state_t       state, state_next;
  logic             tick;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] rx_shift;
  logic             rx_bit;
  logic             load, rise, fall, finish, sample;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_bit      = mosi;
`else
  assign rx_bit = miso;
`endif

  assign tx_next = tx_shift << 1;
  assign sample  = CPHA ? fall : rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    rise       = 1'b0;
    fall       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          rise       = 1'b1;
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (tick) begin
          if (sclk == CPOL) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (bit_cnt == LAST_BIT) state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          finish     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n     <= 1'b1;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        tx_shift <= tx_data;
        mosi     <= tx_data[WIDTH-1];
        cs_n     <= 1'b0;
        busy     <= 1'b1;
        bit_cnt  <= '0;
      end
      if (rise) sclk <= ~CPOL;
      if (fall) begin
        sclk     <= CPOL;
        bit_cnt  <= bit_cnt + BW'(1);
        tx_shift <= tx_next;
        // Once the last bit has been clocked out, mosi returns to its idle level.
        mosi     <= (bit_cnt == LAST_BIT) ? 1'b0 : tx_next[WIDTH-1];
      end
      if (sample) rx_shift <= {rx_shift[WIDTH-2:0], rx_bit};
      if (finish) begin
        cs_n    <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
        rx_data <= rx_shift;
      end
    end
  end

endmodule

// File: doc/spi_master.md
# spi_master

System-clock-domain SPI master (mode 0, MSB first) that drives the serial side of the team's `spi_slave`. It accepts a parallel word from the host via a start strobe and generates `cs_n`, `sclk` and `mosi` with timing the slave expects. It samples `miso` and returns the received word with a one-cycle completion pulse. It sits between the host/register logic and the slave's serial pins.

## Interface
- `WIDTH`, 8: bits per transfer; must match the slave's `WIDTH`.
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; legal values are ≥ 1.
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `start`, in, 1: single-cycle request; sampled only while `busy` = 0.
- `tx_data`, in, `WIDTH`: word to send; captured on the accepted `start` edge.
- `busy`, out, 1: high from the accepted `start` edge until the `cs_n` rising edge.
- `done`, out, 1: one-cycle pulse marking transfer complete.
- `rx_data`, out, `WIDTH`: received word; updated only on `done`.
- `sclk`, out, 1: serial clock; idle low.
- `cs_n`, out, 1: chip select; active low, idle high.
- `mosi`, out, 1: serial data out; idle 0.
- `miso`, in, 1: serial data in from the slave.

## Operation
- **States:** IDLE → SETUP → XFER → HOLD → IDLE.
- **IDLE:** `cs_n`=1, `sclk`=0, `mosi`=0.
  - `start`=1: latch `tx_data` into the tx shift register.
  - Same edge: `cs_n`←0, `mosi`←`tx_data[WIDTH-1]`, `busy`←1, divider cleared, go to SETUP.
- **SETUP:** `sclk` low for `CLK_DIV` cycles, then `sclk`←1 and go to XFER.
- **XFER:** a divider tick every `CLK_DIV` cycles toggles `sclk`.
  - **Rising toggle:** on the same `clk` edge, shift `miso` into the rx shift register at the LSB end, MSB first. `miso` has been stable for `CLK_DIV` cycles because the slave changes it on `sclk` falling.
  - **Falling toggle, bits remaining:** `mosi`←next tx bit.
  - **Falling toggle, after bit `WIDTH`:** `mosi`←0 and go to HOLD.
- **HOLD:** `sclk` low for `CLK_DIV` cycles, then on one edge:
  - `cs_n`←1, `rx_data`←rx shift register, `done`←1, `busy`←0.
  - Go to IDLE.
- **`done`** is high for exactly one cycle.
- **`start` while `busy`=1:** ignored; it is neither queued nor affects the transfer in progress.
- **`start` in the cycle `done`=1:** accepted, because `busy` is already 0. The resulting `cs_n` high time is exactly 1 cycle.
- **`tx_data` changes** after acceptance have no effect on the current transfer.
- **Counters:**
  - Divider: `$clog2(CLK_DIV)` bits, minimum 1; wraps to 0 on each tick.
  - Bit counter: `$clog2(WIDTH+1)` bits, counting falling edges 0..`WIDTH`.
- **Reset, including mid-transfer:** immediately forces
  - `cs_n`=1, `sclk`=0, `mosi`=0
  - `busy`=0, `done`=0, `rx_data`=0
  - state IDLE, counters 0

  No `done` pulse is produced for an aborted transfer.

## Timing
Let E0 be the `clk` edge where `start` is accepted.
- `cs_n` falls at E0.
- Rising `sclk` k (k = 1..`WIDTH`) occurs at E0 + (2k−1)·`CLK_DIV`.
- Falling `sclk` k occurs at E0 + 2k·`CLK_DIV`.
- `cs_n` rises, `done` pulses and `rx_data` updates at E0 + (2·`WIDTH`+1)·`CLK_DIV`.
  - Defaults (`WIDTH`=8, `CLK_DIV`=4): 68 cycles.
  - `CLK_DIV`=1: 17 cycles.
- `sclk` duty cycle is exactly 50%.
- `cs_n` setup before the first rising `sclk` and hold after the last falling `sclk` are each `CLK_DIV` cycles.
- Back-to-back transfers: minimum `cs_n` high time is 1 `clk` cycle. This is sufficient for the slave's `cs_n` edge logic.

## Configuration
- **`SPI_MASTER_LOOPBACK_EN` defined:** the rx shift register samples the internally driven `mosi` instead of the `miso` port, at the same edges. `rx_data` equals the `tx_data` of that transfer; `miso` is ignored. All pin timing is unchanged.
- **Undefined (default):** `miso` is sampled as described under Operation.

## Structure
- **Shared package `spi_pkg`:**
  - State encoding: IDLE/SETUP/XFER/HOLD.
  - Mode constants: CPOL=0, CPHA=0, MSB-first.
  - Counter-width helper function.
- **Sub-module `spi_clk_div`:**
  - Parameter: `CLK_DIV`. Inputs: `clk`, `rst_n`, `en` (clears the count while low).
  - Output: one-cycle `tick` every `CLK_DIV` cycles while `en`=1.
  - `spi_master` toggles `sclk` and advances the state on `tick`.

## Test plan
- **Reset values:** with `rst_n` held low, check `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0 and `rx_data`=0x00. After release, check that no activity occurs without `start`.
- **Single transfer:** `tx_data`=0xA5, slave `tx_data`=0x3C, `CLK_DIV`=4 → 8 `sclk` pulses; `done` at E0+68; master `rx_data`=0x3C; slave `rx_data`=0xA5 with `rx_ready` asserted.
- **Ignored start / back-to-back:**
  - Pulse `start` at E0+20 during the transfer → ignored.
  - Assert `start` with 0x5A in the `done` cycle → second transfer starts after a 1-cycle `cs_n` high.
  - Expected: first `rx_data`=0x3C, second `rx_data` equals the slave's new word.
- **Edge values:** `CLK_DIV`=1, words 0x00 and 0xFF → `done` at E0+17; exact `sclk` waveform 0101…; data correct.
- **Mid-transfer reset:** assert `rst_n`=0 at E0+30 → all outputs immediately at reset values, no `done`. A subsequent transfer of 0x81 completes correctly.
- **Loopback:** with `SPI_MASTER_LOOPBACK_EN` defined and `miso` tied to 1, send 0x96 → `rx_data`=0x96.
